ula_74181_seq_ctrl: RTL and testbench

- Multi-nibble sequencer around one 4-bit 74181 ALU slice (`module_ula_74181`).
- Accepts a wide operation (NIBBLES×4 bits) over a valid/ready request channel.
- Drives the single slice one nibble per cycle, LSB first, and propagates carry/borrow between nibbles.
- Accumulates the wide result and returns it on a valid/ready response channel; sits between a requester (CPU/testbench datapath) and the ALU.

---
 rtl/ula_74181_pkg.sv | 36 +++
 rtl/module_ula_74181.sv | 66 ++++++
 rtl/ula_74181_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_ula_74181_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_74181_pkg.sv
// Shared types for the multi-nibble 74181 sequencer.
// FSM states, function-select codes and carry-normalization helper.
package ula_74181_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef logic [3:0] fsel_t;

    localparam fsel_t FS_0 = 4'h0;
    localparam fsel_t FS_1 = 4'h1;
    localparam fsel_t FS_2 = 4'h2;
    localparam fsel_t FS_3 = 4'h3;
    localparam fsel_t FS_4 = 4'h4;
    localparam fsel_t FS_5 = 4'h5;
    localparam fsel_t FS_6 = 4'h6;
    localparam fsel_t FS_7 = 4'h7;
    localparam fsel_t FS_8 = 4'h8;
    localparam fsel_t FS_9 = 4'h9;
    localparam fsel_t FS_A = 4'hA;
    localparam fsel_t FS_B = 4'hB;
    localparam fsel_t FS_C = 4'hC;
    localparam fsel_t FS_D = 4'hD;
    localparam fsel_t FS_E = 4'hE;
    localparam fsel_t FS_F = 4'hF;

    // Ops whose slice carry-out is a borrow and must be inverted.
    function automatic logic is_borrow_op(input fsel_t s);
        return (s == FS_3) || (s == FS_6) || (s == FS_7) ||
               (s == FS_B) || (s == FS_F);
    endfunction

endpackage

// File: rtl/module_ula_74181.sv
// Combinational 4-bit 74181 slice, active-high data and carry-in.
// Subtract-type ops report a borrow on c_out_o; b_in_i cancels carry-in.
module module_ula_74181 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       c_in_i,
    input  logic       b_in_i,
    output logic [3:0] f_o,
    output logic       c_out_o,
    output logic       a_eq_b_o
);
    import ula_74181_pkg::*;

    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] lf;
    logic       ci;
    logic [4:0] sum;
    logic [4:0] dif;

    assign ci       = c_in_i & ~b_in_i;
    assign sum      = {1'b0, p} + {1'b0, q} + {4'b0, ci};
    assign dif      = {1'b0, p} + {1'b0, ~q} + {4'b0, ci};
    assign a_eq_b_o = (a_i == b_i);

    // Operand pair for the adder and the logic-mode result per code.
    always_comb begin
        p  = '0;
        q  = '0;
        lf = '0;
        unique case (s_i)
            FS_0: begin p = a_i;         q = '0;         lf = ~a_i;          end
            FS_1: begin p = a_i | b_i;   q = '0;         lf = ~(a_i | b_i);  end
            FS_2: begin p = a_i | ~b_i;  q = '0;         lf = ~a_i & b_i;    end
            FS_3: begin p = '0;          q = '0;         lf = '0;            end
            FS_4: begin p = a_i;         q = a_i & ~b_i; lf = ~(a_i & b_i);  end
            FS_5: begin p = a_i | b_i;   q = a_i & ~b_i; lf = ~b_i;          end
            FS_6: begin p = a_i;         q = b_i;        lf = a_i ^ b_i;     end
            FS_7: begin p = a_i & ~b_i;  q = '0;         lf = a_i & ~b_i;    end
            FS_8: begin p = a_i;         q = a_i & b_i;  lf = ~a_i | b_i;    end
            FS_9: begin p = a_i;         q = b_i;        lf = ~(a_i ^ b_i);  end
            FS_A: begin p = a_i | ~b_i;  q = a_i & b_i;  lf = b_i;           end
            FS_B: begin p = a_i & b_i;   q = '0;         lf = a_i & b_i;     end
            FS_C: begin p = a_i;         q = a_i;        lf = 4'hF;          end
            FS_D: begin p = a_i | b_i;   q = a_i;        lf = a_i | ~b_i;    end
            FS_E: begin p = a_i | ~b_i;  q = a_i;        lf = a_i | b_i;     end
            FS_F: begin p = a_i;         q = '0;         lf = a_i;           end
        endcase
    end

    // Select logic result, subtract path (borrow out) or add path.
    always_comb begin
        f_o     = sum[3:0];
        c_out_o = sum[4];
        if (m_i) begin
            f_o     = lf;
            c_out_o = 1'b0;
        end else if (is_borrow_op(s_i)) begin
            f_o     = dif[3:0];
            c_out_o = ~dif[4];
        end
    end

endmodule

// File: rtl/ula_74181_seq_ctrl.sv
// Sequencer driving one 74181 slice nibble by nibble, LSB first.
// Optional rsp_zero output enabled by ULA_SEQ_ZERO_FLAG_EN.
module ula_74181_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic [3:0]             req_s,
    input  logic                   req_m,
    input  logic                   req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_f,
    output logic                   rsp_cout,
    output logic                   rsp_eq,
    output logic                   busy
`ifdef ULA_SEQ_ZERO_FLAG_EN
   ,output logic                   rsp_zero
`endif
);
    import ula_74181_pkg::*;

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [W-1:0]    res_d;
    fsel_t           s_q;
    logic            m_q;
    logic            carry_q;
    logic            eq_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            busy_q;
    logic [W-1:0]    rsp_f_q;
    logic            rsp_cout_q;
    logic            rsp_eq_q;
    logic            rsp_zero_q;

    logic [IW+1:0]   base;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      f_nib;
    logic            c_out;
    logic            a_eq_b;
    logic            c_next;
    logic            last;

    assign base   = {idx_q, 2'b00};
    assign a_nib  = a_q[base +: 4];
    assign b_nib  = b_q[base +: 4];
    assign c_next = m_q ? 1'b0 : (c_out ^ is_borrow_op(s_q));
    assign last   = (idx_q == IW'(NIBBLES - 1));

    module_ula_74181 u_slice (
        .a_i      (a_nib),
        .b_i      (b_nib),
        .s_i      (s_q),
        .m_i      (m_q),
        .c_in_i   (carry_q),
        .b_in_i   (1'b0),
        .f_o      (f_nib),
        .c_out_o  (c_out),
        .a_eq_b_o (a_eq_b)
    );

    // Merge the current nibble result into the accumulator.
    always_comb begin
        res_d = res_q;
        res_d[base +: 4] = f_nib;
    end

    // Control FSM with latched operands and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            s_q         <= FS_0;
            m_q         <= 1'b0;
            carry_q     <= 1'b0;
            eq_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_f_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        s_q         <= req_s;
                        m_q         <= req_m;
                        carry_q     <= req_m ? 1'b0 : req_cin;
                        idx_q       <= '0;
                        eq_q        <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= res_d;
                    eq_q    <= eq_q & a_eq_b;
                    carry_q <= c_next;
                    idx_q   <= idx_q + IW'(1);
                    if (last) begin
                        idx_q       <= '0;
                        rsp_f_q     <= res_d;
                        rsp_cout_q  <= c_next;
                        rsp_eq_q    <= eq_q & a_eq_b;
                        rsp_zero_q  <= (res_d == '0);
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_eq    = rsp_eq_q;

`ifdef ULA_SEQ_ZERO_FLAG_EN
    assign rsp_zero = rsp_zero_q;
`else
    logic unused_zero;
    assign unused_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_ula_74181_seq_ctrl.sv
// Randomized bench for ula_74181_seq_ctrl with a wide-arithmetic model.
// Directed cases pin the model and the DUT to hand-computed values.
module tb_ula_74181_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_s;
    logic         req_m;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
    logic         rsp_eq;
    logic         busy;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    logic         rsp_zero;
`endif

    int vecs = 0;
    int miss = 0;

    ula_74181_seq_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .req_m     (req_m),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
`ifdef ULA_SEQ_ZERO_FLAG_EN
       ,.rsp_zero  (rsp_zero)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Whole-word reference: result of the 74181 function on W bits.
    function automatic void ref_op(
        input  logic [W-1:0] a, input logic [W-1:0] b,
        input  logic [3:0] s, input logic m, input logic cin,
        output logic [W-1:0] f, output logic co, output logic eq);
        logic [W-1:0] p, q;
        logic [W:0]   full;
        bit           sub;
        eq = (a == b);
        f = '0; co = 1'b0; p = '0; q = '0;
        sub = (s == 3) || (s == 6) || (s == 7) || (s == 11) || (s == 15);
        if (m) begin
            case (s)
                0: f = ~a;        1: f = ~(a | b);
                2: f = ~a & b;    3: f = '0;
                4: f = ~(a & b);  5: f = ~b;
                6: f = a ^ b;     7: f = a & ~b;
                8: f = ~a | b;    9: f = ~(a ^ b);
                10: f = b;        11: f = a & b;
                12: f = '1;       13: f = a | ~b;
                14: f = a | b;    default: f = a;
            endcase
        end else begin
            case (s)
                0: begin p = a;      q = '0;     end
                1: begin p = a | b;  q = '0;     end
                2: begin p = a | ~b; q = '0;     end
                3: begin p = '0;     q = '0;     end
                4: begin p = a;      q = a & ~b; end
                5: begin p = a | b;  q = a & ~b; end
                6: begin p = a;      q = b;      end
                7: begin p = a & ~b; q = '0;     end
                8: begin p = a;      q = a & b;  end
                9: begin p = a;      q = b;      end
                10: begin p = a | ~b; q = a & b; end
                11: begin p = a & b; q = '0;     end
                12: begin p = a;     q = a;      end
                13: begin p = a | b; q = a;      end
                14: begin p = a | ~b; q = a;     end
                default: begin p = a; q = '0;    end
            endcase
            if (sub) begin
                f  = p - q - W'(1) + W'(cin);
                co = ({1'b0, p} + {{W{1'b0}}, cin}) > {1'b0, q};
            end else begin
                full = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, cin};
                f  = full[W-1:0];
                co = full[W];
            end
        end
    endfunction

    int           ph = 0;
    int           cnt = 0;
    logic [W-1:0] pf, ef = '0;
    logic         pc, ec = 1'b0;
    logic         pe, ee = 1'b0;

    // Model: an op takes N cycles, then waits for the response handshake.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = 0; cnt = 0; ef = '0; ec = 1'b0; ee = 1'b0;
        end else begin
            case (ph)
                0: if (req_valid) begin
                    ref_op(req_a, req_b, req_s, req_m, req_cin, pf, pc, pe);
                    cnt = N;
                    ph  = 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        ph = 2; ef = pf; ec = pc; ee = pe;
                    end
                end
                default: if (rsp_ready) ph = 0;
            endcase
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        logic [W+5:0] got, want;
        @(negedge clk);
        got  = {req_ready, rsp_valid, busy, rsp_cout, rsp_eq, rsp_f};
        want = {ph == 0, ph == 2, ph != 0, ec, ee, ef};
`ifdef ULA_SEQ_ZERO_FLAG_EN
        got[W+5]  = rsp_zero;
        want[W+5] = (ef == '0) && (ec | ee | 1'b1) && (ph != 0 || ef == '0)
                    ? (ef == '0) : 1'b0;
`else
        got[W+5]  = 1'b0;
        want[W+5] = 1'b0;
`endif
        chk("cycle", 64'(got), 64'(want));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m,
                          input logic cin, input int bp, input bit lit,
                          input logic [W-1:0] xf, input logic xc,
                          input logic xe);
        int g;
        int lat;
        g = 0;
        while (!req_ready && g < 40) begin
            tick();
            g++;
        end
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            req_a = W'($urandom);
            req_b = W'($urandom);
            req_s = 4'($urandom);
            rsp_ready = 1'($urandom);
            tick();
            lat++;
        end
        rsp_ready = 1'b0;
        chk("latency", 64'(lat), 64'(N));
        if (lit) begin
            chk("rsp_f", 64'(rsp_f), 64'(xf));
            chk("rsp_cout", 64'(rsp_cout), 64'(xc));
            chk("rsp_eq", 64'(rsp_eq), 64'(xe));
`ifdef ULA_SEQ_ZERO_FLAG_EN
            chk("rsp_zero", 64'(rsp_zero), 64'(xf == '0));
`endif
        end
        repeat (bp) begin
            req_valid = 1'b1;
            req_a = W'($urandom);
            tick();
            chk("bp_ready", 64'({req_ready, rsp_valid}), 64'(2'b01));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] mf;
        logic         mc, me;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cin = 1'b0;
        repeat (3) tick();
        chk("reset", 64'({req_ready, rsp_valid, busy, rsp_cout, rsp_eq, rsp_f}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
        rst_n = 1'b1;
        tick();

        ref_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, mf, mc, me);
        chk("model_add", 64'({mf, mc, me}), 64'({16'h0100, 1'b0, 1'b0}));
        ref_op(16'h0000, 16'h0001, 4'h6, 1'b0, 1'b1, mf, mc, me);
        chk("model_sub", 64'({mf, mc, me}), 64'({16'hFFFF, 1'b0, 1'b0}));
        ref_op(16'hA5A5, 16'hFFFF, 4'h6, 1'b1, 1'b1, mf, mc, me);
        chk("model_xor", 64'({mf, mc, me}), 64'({16'h5A5A, 1'b0, 1'b0}));

        run_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, 1, 16'h0100, 0, 0);
        run_op(16'h1000, 16'h0001, 4'h6, 1'b0, 1'b1, 0, 1, 16'h0FFF, 1, 0);
        run_op(16'h0000, 16'h0001, 4'h6, 1'b0, 1'b1, 0, 1, 16'hFFFF, 0, 0);
        run_op(16'h0000, 16'h0000, 4'hF, 1'b0, 1'b0, 0, 1, 16'hFFFF, 0, 1);
        run_op(16'hFFFF, 16'h0000, 4'h9, 1'b0, 1'b1, 0, 1, 16'h0000, 1, 0);
        run_op(16'hA5A5, 16'hFFFF, 4'h6, 1'b1, 1'b1, 0, 1, 16'h5A5A, 0, 0);
        run_op(16'h1234, 16'h1234, 4'h6, 1'b1, 1'b1, 0, 1, 16'h0000, 0, 1);
        run_op(16'h0F0F, 16'h0101, 4'h9, 1'b0, 1'b0, 3, 1, 16'h1010, 0, 0);

        req_a = 16'h00FF; req_b = 16'h0001; req_s = 4'h9;
        req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid", 64'({req_ready, rsp_valid, busy, rsp_cout, rsp_eq, rsp_f}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
        #2;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_rsp", 64'({rsp_valid, busy}), 64'(2'b00));
        run_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, 1, 16'h0100, 0, 0);

        for (int i = 0; i < 120; i++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            else rb = W'($urandom);
            run_op(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0);
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
